// File: rtl/dsp_job_sequencer_pkg.sv
// rtl/dsp_job_sequencer_pkg.sv - shared state enum, operand field layout and result width
package dsp_job_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_DSP,
    OFFER,
    PACE,
    DONE
  } state_t;

  // Operand word layout in mem_dout: A=[6:0], B=[14:7], C=[21:15]
  localparam int A_LSB  = 0;
  localparam int A_W    = 7;
  localparam int B_LSB  = 7;
  localparam int B_W    = 8;
  localparam int C_LSB  = 15;
  localparam int C_W    = 7;
  localparam int OPND_W = 22;
  localparam int RES_W  = 16;
  localparam int LAT_W  = 3;

endpackage

// File: rtl/lat_counter.sv
// rtl/lat_counter.sv - loadable down-counter with a zero flag for fixed-latency waits
module lat_counter
#(
  parameter int W = 3
)
(
  input  logic         clock_100Mhz,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dsp_job_sequencer.sv
// rtl/dsp_job_sequencer.sv - walks DEPTH operand entries through a multiply-add and
// offers each result with valid/ready, paced by step_en between entries
module dsp_job_sequencer
  import dsp_job_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int MEM_LAT = 1,
  parameter int DSP_LAT = 3
)
(
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              step_en,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_dout,
  output logic [A_W-1:0]    dsp_a,
  output logic [B_W-1:0]    dsp_b,
  output logic [C_W-1:0]    dsp_c,
  input  logic [RES_W-1:0]  dsp_p,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_index,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [LAT_W-1:0]  MEM_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0]  DSP_LOAD = LAT_W'(DSP_LAT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   index;
  logic [OPND_W-1:0]   operand;
  logic                mem_zero;
  logic                dsp_zero;
  logic                unused_mem_bits;

  // Counters sit preloaded outside their state, so each wait lasts exactly *_LAT cycles
  lat_counter #(.W(LAT_W)) u_mem_cnt (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .load         (state != FETCH),
    .load_val     (MEM_LOAD),
    .dec          (state == FETCH),
    .zero         (mem_zero)
  );

  lat_counter #(.W(LAT_W)) u_dsp_cnt (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .load         (state != WAIT_DSP),
    .load_val     (DSP_LOAD),
    .dec          (state == WAIT_DSP),
    .zero         (dsp_zero)
  );

  // The operand register drives the multiply-add directly, so operands change only on FETCH exit
  assign dsp_a = operand[A_LSB +: A_W];
  assign dsp_b = operand[B_LSB +: B_W];
  assign dsp_c = operand[C_LSB +: C_W];

  assign unused_mem_bits = ^mem_dout[23:OPND_W];

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      operand   <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        mem_en    <= 1'b0;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= FETCH;
              index    <= '0;
              mem_en   <= 1'b1;
              mem_addr <= '0;
              busy     <= 1'b1;
            end
          end
          FETCH: begin
            if (mem_zero) begin
              operand <= mem_dout[OPND_W-1:0];
              mem_en  <= 1'b0;
              state   <= ISSUE;
            end
          end
          ISSUE: begin
            state <= WAIT_DSP;
          end
          WAIT_DSP: begin
            if (dsp_zero) begin
              res_data  <= dsp_p;
              res_index <= index;
              res_valid <= 1'b1;
              state     <= OFFER;
            end
          end
          OFFER: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (index == LAST_IDX) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                index <= index + ADDR_W'(1);
                state <= PACE;
              end
            end
          end
          PACE: begin
            if (step_en) begin
              state    <= FETCH;
              mem_en   <= 1'b1;
              mem_addr <= index;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_job_sequencer.sv
// tb/tb_dsp_job_sequencer.sv - directed bench: default-latency instance plus a MEM_LAT=2/DSP_LAT=4 instance
module tb_dsp_job_sequencer;

  logic clock_100Mhz = 1'b0;
  always #5 clock_100Mhz = ~clock_100Mhz;

  logic reset;

  logic        start0, abort0, step0, res_ready0;
  logic        mem_en0, res_valid0, busy0, done0;
  logic [1:0]  mem_addr0, res_index0;
  logic [23:0] mem_dout0;
  logic [6:0]  dsp_a0, dsp_c0;
  logic [7:0]  dsp_b0;
  logic [15:0] dsp_p0, res_data0;

  logic        start1, abort1, step1, res_ready1;
  logic        mem_en1, res_valid1, busy1, done1;
  logic [1:0]  mem_addr1, res_index1;
  logic [23:0] mem_dout1;
  logic [6:0]  dsp_a1, dsp_c1;
  logic [7:0]  dsp_b1;
  logic [15:0] dsp_p1, res_data1;

  dsp_job_sequencer dut0 (
    .clock_100Mhz (clock_100Mhz), .reset (reset),
    .start (start0), .abort (abort0), .step_en (step0),
    .mem_en (mem_en0), .mem_addr (mem_addr0), .mem_dout (mem_dout0),
    .dsp_a (dsp_a0), .dsp_b (dsp_b0), .dsp_c (dsp_c0), .dsp_p (dsp_p0),
    .res_valid (res_valid0), .res_ready (res_ready0), .res_data (res_data0),
    .res_index (res_index0), .busy (busy0), .done (done0)
  );

  dsp_job_sequencer #(.DEPTH(4), .ADDR_W(2), .MEM_LAT(2), .DSP_LAT(4)) dut1 (
    .clock_100Mhz (clock_100Mhz), .reset (reset),
    .start (start1), .abort (abort1), .step_en (step1),
    .mem_en (mem_en1), .mem_addr (mem_addr1), .mem_dout (mem_dout1),
    .dsp_a (dsp_a1), .dsp_b (dsp_b1), .dsp_c (dsp_c1), .dsp_p (dsp_p1),
    .res_valid (res_valid1), .res_ready (res_ready1), .res_data (res_data1),
    .res_index (res_index1), .busy (busy1), .done (done1)
  );

  // Memory: MEM_LAT=1 reads combinationally within the FETCH cycle, MEM_LAT=2 adds one register
  logic [23:0] mem_tab [4];
  logic [23:0] mem_q1;
  assign mem_dout0 = mem_tab[mem_addr0];
  always @(posedge clock_100Mhz) if (mem_en1) mem_q1 <= mem_tab[mem_addr1];
  assign mem_dout1 = mem_q1;

  // Multiply-add models with DSP_LAT pipeline registers
  logic [15:0] p0 [3];
  logic [15:0] p1 [4];
  always @(posedge clock_100Mhz) begin
    p0[0] <= 16'(dsp_a0) * 16'(dsp_b0) + 16'(dsp_c0);
    p0[1] <= p0[0];
    p0[2] <= p0[1];
    p1[0] <= 16'(dsp_a1) * 16'(dsp_b1) + 16'(dsp_c1);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    p1[3] <= p1[2];
  end
  assign dsp_p0 = p0[2];
  assign dsp_p1 = p1[3];

  typedef struct {
    logic [6:0]  a;
    logic [7:0]  b;
    logic [6:0]  c;
    logic [15:0] exp_p;
    logic [1:0]  exp_idx;
  } vec_t;

  vec_t vecs [4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid0(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock_100Mhz);
      if (res_valid0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL res_valid0 timeout: got 0 after %0d cycles, expected 1", max_cyc);
    end
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge clock_100Mhz);
    start0 = 1'b0;
  endtask

  task automatic pulse_step0();
    step0 = 1'b1;
    @(negedge clock_100Mhz);
    step0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt, bad_v, bad_d, rd, dn;

    vecs[0] = '{a: 7'd3,   b: 8'd5,   c: 7'd1,   exp_p: 16'd16,    exp_idx: 2'd0};
    vecs[1] = '{a: 7'd10,  b: 8'd10,  c: 7'd0,   exp_p: 16'd100,   exp_idx: 2'd1};
    vecs[2] = '{a: 7'd127, b: 8'd255, c: 7'd127, exp_p: 16'd32512, exp_idx: 2'd2};
    vecs[3] = '{a: 7'd0,   b: 8'd0,   c: 7'd0,   exp_p: 16'd0,     exp_idx: 2'd3};
    for (int i = 0; i < 4; i++) mem_tab[i] = {2'b11, vecs[i].c, vecs[i].b, vecs[i].a};

    reset = 1'b1;
    start0 = 0; abort0 = 0; step0 = 0; res_ready0 = 0;
    start1 = 0; abort1 = 0; step1 = 0; res_ready1 = 0;

    #1;
    check("reset busy", busy0, 0);
    check("reset mem_en", mem_en0, 0);
    check("reset res_valid", res_valid0, 0);
    check("reset res_data", res_data0, 0);
    check("reset dsp_abc", {dsp_a0, dsp_b0, dsp_c0}, 0);
    check("reset done", done0, 0);
    repeat (3) @(negedge clock_100Mhz);
    reset = 1'b0;
    @(negedge clock_100Mhz);

    // Start-to-valid latency on the MEM_LAT=2 / DSP_LAT=4 instance
    res_ready1 = 1'b1;
    start1 = 1'b1;
    n = 0;
    cnt = 0;
    do begin
      @(negedge clock_100Mhz);
      start1 = 1'b0;
      n++;
      if (mem_en1) cnt++;
    end while (!res_valid1 && n < 40);
    check("latency cycles", n, 8);
    check("latency mem_en cycles", cnt, 2);
    check("latency res_data", res_data1, 16);
    check("latency res_index", res_index1, 0);

    // Nominal run, table-driven
    res_ready0 = 1'b1;
    pulse_start0();
    for (int i = 0; i < 4; i++) begin
      wait_valid0(60);
      check("nominal res_data", res_data0, vecs[i].exp_p);
      check("nominal res_index", res_index0, vecs[i].exp_idx);
      check("nominal operands", {dsp_c0, dsp_b0, dsp_a0}, {vecs[i].c, vecs[i].b, vecs[i].a});
      check("nominal busy", busy0, 1);
      @(negedge clock_100Mhz);
      check("nominal res_valid drop", res_valid0, 0);
      if (i < 3) begin
        repeat (18) @(negedge clock_100Mhz);
        pulse_step0();
      end else begin
        dn = done0;
        repeat (5) begin
          @(negedge clock_100Mhz);
          dn += done0;
        end
        check("nominal done pulses", dn, 1);
        check("nominal busy after done", busy0, 0);
      end
    end

    // Backpressure on entry 1
    res_ready0 = 1'b0;
    pulse_start0();
    wait_valid0(60);
    check("bp entry0 data", res_data0, 16);
    res_ready0 = 1'b1;
    @(negedge clock_100Mhz);
    res_ready0 = 1'b0;
    pulse_step0();
    wait_valid0(60);
    check("bp entry1 data", res_data0, 100);
    bad_v = 0; bad_d = 0; rd = 0;
    repeat (50) begin
      @(negedge clock_100Mhz);
      if (!res_valid0) bad_v++;
      if (res_data0 !== 16'd100) bad_d++;
      if (mem_en0) rd++;
    end
    check("bp valid drops", bad_v, 0);
    check("bp data changes", bad_d, 0);
    check("bp memory reads", rd, 0);
    abort0 = 1'b1;
    res_ready0 = 1'b1;
    @(negedge clock_100Mhz);
    abort0 = 1'b0;
    res_ready0 = 1'b0;
    check("abort in offer res_valid", res_valid0, 0);
    check("abort in offer busy", busy0, 0);

    // Abort during WAIT_DSP of entry 2, then restart from index 0
    res_ready0 = 1'b1;
    pulse_start0();
    for (int i = 0; i < 2; i++) begin
      wait_valid0(60);
      @(negedge clock_100Mhz);
      pulse_step0();
    end
    check("abort fetch addr", {mem_en0, mem_addr0}, {1'b1, 2'd2});
    repeat (2) @(negedge clock_100Mhz);
    abort0 = 1'b1;
    @(negedge clock_100Mhz);
    abort0 = 1'b0;
    check("abort busy", busy0, 0);
    check("abort res_valid", res_valid0, 0);
    cnt = 0;
    repeat (30) begin
      @(negedge clock_100Mhz);
      cnt += int'(done0) + int'(res_valid0) + int'(mem_en0);
    end
    check("abort quiet outputs", cnt, 0);
    pulse_start0();
    check("restart fetch addr", {mem_en0, mem_addr0}, {1'b1, 2'd0});
    wait_valid0(60);
    check("restart res_index", res_index0, 0);
    check("restart res_data", res_data0, 16);
    abort0 = 1'b1;
    @(negedge clock_100Mhz);
    abort0 = 1'b0;

    // step_en during OFFER and start during PACE are ignored
    res_ready0 = 1'b0;
    pulse_start0();
    wait_valid0(60);
    repeat (3) begin
      pulse_step0();
      @(negedge clock_100Mhz);
    end
    check("ignored step res_index", {res_valid0, res_index0}, {1'b1, 2'd0});
    res_ready0 = 1'b1;
    @(negedge clock_100Mhz);
    res_ready0 = 1'b0;
    rd = 0;
    for (int i = 0; i < 10; i++) begin
      start0 = (i == 3);
      @(negedge clock_100Mhz);
      if (mem_en0) rd++;
    end
    start0 = 1'b0;
    check("ignored pace fetches", rd, 0);
    check("ignored pace busy", busy0, 1);
    pulse_step0();
    check("pace fetch addr", {mem_en0, mem_addr0}, {1'b1, 2'd1});
    wait_valid0(60);
    check("pace entry1 index", res_index0, 1);
    check("pace entry1 data", res_data0, 100);
    res_ready0 = 1'b1;
    @(negedge clock_100Mhz);
    res_ready0 = 1'b0;
    abort0 = 1'b1;
    step0 = 1'b1;
    @(negedge clock_100Mhz);
    abort0 = 1'b0;
    step0 = 1'b0;
    check("abort beats step busy", busy0, 0);
    check("abort beats step mem_en", mem_en0, 0);
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clock_100Mhz);
    start0 = 1'b0;
    abort0 = 1'b0;
    check("start+abort idle", {busy0, mem_en0}, 0);

    // Asynchronous reset mid-OFFER
    pulse_start0();
    wait_valid0(60);
    #2;
    reset = 1'b1;
    #1;
    check("async reset res_valid", res_valid0, 0);
    check("async reset busy", busy0, 0);
    check("async reset res_data", res_data0, 0);
    check("async reset operands", {dsp_a0, dsp_b0, dsp_c0}, 0);
    @(negedge clock_100Mhz);
    reset = 1'b0;
    dn = 0;
    repeat (10) begin
      @(negedge clock_100Mhz);
      dn += int'(done0) + int'(busy0);
    end
    check("post reset no done", dn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
